// File: rtl/second_unpool_if.sv
// Stream bundle for the 2x unpool stage:
// pooled words in, upsampled raster words out.
interface second_unpool_if #(
    parameter int DW = 16
);
    logic          Din_Valid;
    logic [DW-1:0] Din;
    logic          Din_Ready;
    logic          Dout_Valid;
    logic [DW-1:0] Dout;
    logic          Dout_Eol;
    logic          Frame_Done;

    modport master (
        output Din_Valid, Din,
        input  Din_Ready, Dout_Valid, Dout, Dout_Eol, Frame_Done
    );

    modport slave (
        input  Din_Valid, Din,
        output Din_Ready, Dout_Valid, Dout, Dout_Eol, Frame_Done
    );
endinterface

// File: rtl/second_unpool.sv
// 2x nearest-neighbour unpool: buffers one pooled row,
// then emits it twice with every word doubled.
module second_unpool #(
    parameter int IN_W = 8,
    parameter int DW   = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    second_unpool_if.slave  bus
);
    localparam int ICW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int OCW = ICW + 1;

    typedef enum logic {FILL, EMIT} state_t;

    state_t         state_q, state_d;
    logic [ICW-1:0] icol_q, icol_d;
    logic [ICW-1:0] irow_q, irow_d;
    logic [OCW-1:0] ocol_q, ocol_d;
    logic           rep_q, rep_d;
    logic [DW-1:0]  buf_q [IN_W];
    logic           wr_en;
    logic [DW-1:0]  dout_q, dout_d;
    logic           dv_q, dv_d;
    logic           eol_q, eol_d;
    logic           fd_q, fd_d;

    assign bus.Din_Ready  = (state_q == FILL);
    assign bus.Dout_Valid = dv_q;
    assign bus.Dout       = dout_q;
    assign bus.Dout_Eol   = eol_q;
    assign bus.Frame_Done = fd_q;

    // Next-state: fill the row buffer, then replay each word twice per row, two rows.
    always_comb begin
        state_d = state_q;
        icol_d  = icol_q;
        irow_d  = irow_q;
        ocol_d  = ocol_q;
        rep_d   = rep_q;
        wr_en   = 1'b0;
        dout_d  = '0;
        dv_d    = 1'b0;
        eol_d   = 1'b0;
        fd_d    = 1'b0;
        unique case (state_q)
            FILL: begin
                if (bus.Din_Valid) begin
                    wr_en = 1'b1;
                    if (icol_q == ICW'(IN_W - 1)) begin
                        icol_d  = '0;
                        ocol_d  = '0;
                        rep_d   = 1'b0;
                        state_d = EMIT;
                    end else begin
                        icol_d = icol_q + 1'b1;
                    end
                end
            end
            EMIT: begin
                dout_d = buf_q[ocol_q[OCW-1:1]];
                dv_d   = 1'b1;
                if (ocol_q == OCW'(2 * IN_W - 1)) begin
                    eol_d  = 1'b1;
                    ocol_d = '0;
                    rep_d  = ~rep_q;
                    if (rep_q) begin
                        state_d = FILL;
                        if (irow_q == ICW'(IN_W - 1)) begin
                            fd_d   = 1'b1;
                            irow_d = '0;
                        end else begin
                            irow_d = irow_q + 1'b1;
                        end
                    end
                end else begin
                    ocol_d = ocol_q + 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Control state and registered output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            icol_q  <= '0;
            irow_q  <= '0;
            ocol_q  <= '0;
            rep_q   <= 1'b0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            eol_q   <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            icol_q  <= icol_d;
            irow_q  <= irow_d;
            ocol_q  <= ocol_d;
            rep_q   <= rep_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            eol_q   <= eol_d;
            fd_q    <= fd_d;
        end
    end

    // Row buffer, written only by accepted words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IN_W; i++) buf_q[i] <= '0;
        end else if (wr_en) begin
            buf_q[icol_q] <= bus.Din;
        end
    end
endmodule

// File: tb/tb_second_unpool.sv
// Bench for second_unpool: table of row/frame runs
// with a scoreboard, plus a reset-mid-emit sequence.
module tb_second_unpool;
    localparam int IN_W = 8;
    localparam int DW   = 16;

    typedef struct packed {
        logic          eol;
        logic          done;
        logic [DW-1:0] d;
    } exp_t;

    typedef struct {
        string      name;
        logic [15:0] base;
        logic [15:0] step;
        int         gap;
        bit         ffff;
        int         rows;
        int         exp_out;
        int         exp_eol;
        int         exp_done;
    } vec_t;

    logic clk;
    logic rst_n;

    second_unpool_if #(.DW(DW)) bus ();

    second_unpool #(.IN_W(IN_W), .DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t sb[$];
    int   total = 0;
    int   passed = 0;
    int   out_cnt = 0;
    int   eol_cnt = 0;
    int   done_cnt = 0;
    int   prev_done_at = 0;
    int   last_done_at = 0;
    int   model_irow = 0;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.Dout_Valid === 1'b1) begin
                out_cnt++;
                if (bus.Dout_Eol) eol_cnt++;
                if (bus.Frame_Done) begin
                    done_cnt++;
                    prev_done_at = last_done_at;
                    last_done_at = out_cnt;
                end
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("dout", {14'd0, bus.Dout_Eol, bus.Frame_Done, bus.Dout},
                        {14'd0, e.eol, e.done, e.d});
                end
            end else if (bus.Dout_Eol !== 1'b0 || bus.Frame_Done !== 1'b0 ||
                         bus.Dout !== '0) begin
                chk("idle_outputs", {bus.Dout_Eol, bus.Frame_Done, bus.Dout}, 0);
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.Din_Valid = 1'b0;
        bus.Din = '0;
        sb.delete();
        model_irow = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [15:0] d, input int gap, input bit ffff);
        int guard = 0;
        bit acc = 1'b0;
        while (!acc) begin
            if (!bus.Din_Ready) begin
                bus.Din_Valid = ffff;
                bus.Din = 16'hFFFF;
            end else if (gap > 0 && int'($urandom_range(99)) < gap) begin
                bus.Din_Valid = 1'b0;
                bus.Din = 16'hFFFF;
            end else begin
                bus.Din_Valid = 1'b1;
                bus.Din = d;
            end
            acc = bus.Din_Valid && bus.Din_Ready;
            @(posedge clk);
            #1;
            if (!acc) begin
                guard++;
                if (guard > 2000) begin
                    chk("accept_timeout", 0, 1);
                    return;
                end
            end
        end
    endtask

    task automatic send_row(input logic [15:0] base, input logic [15:0] step,
                            input int idx0, input int gap, input bit ffff,
                            input int abort);
        logic [15:0] w[IN_W];
        int n;
        int first;
        exp_t e;
        for (int c = 0; c < IN_W; c++) w[c] = 16'(base + step * (idx0 + c));
        for (int c = 0; c < IN_W - 1; c++) send_word(w[c], gap, ffff);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 2 * IN_W; c++) begin
                e.d = w[c >> 1];
                e.eol = (c == 2 * IN_W - 1);
                e.done = (r == 1) && (c == 2 * IN_W - 1) && (model_irow == IN_W - 1);
                sb.push_back(e);
            end
        end
        model_irow = (model_irow + 1) % IN_W;
        send_word(w[IN_W - 1], gap, ffff);
        n = 0;
        first = -1;
        while (!bus.Din_Ready && n < 200) begin
            bus.Din_Valid = ffff;
            bus.Din = 16'hFFFF;
            @(posedge clk);
            #1;
            n++;
            if (first < 0 && bus.Dout_Valid) first = n;
            if (abort > 0 && n == abort) begin
                rst_n = 1'b0;
                #1;
                chk("rst_dout_valid", bus.Dout_Valid, 0);
                chk("rst_dout", bus.Dout, 0);
                chk("rst_din_ready", bus.Din_Ready, 1);
                sb.delete();
                model_irow = 0;
                bus.Din_Valid = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
        end
        chk("first_out_latency", first, 1);
        chk("emit_cycles", n, 4 * IN_W);
    endtask

    initial begin
        int o0, e0, d0;
        tbl[0] = '{"single_row", 16'd1, 16'd1, 0, 1'b0, 1, 32, 2, 0};
        tbl[1] = '{"full_frame", 16'd0, 16'd1, 0, 1'b0, 8, 256, 16, 1};
        tbl[2] = '{"input_gaps", 16'd1, 16'd1, 40, 1'b0, 1, 32, 2, 0};
        tbl[3] = '{"ignored_ffff", 16'h0100, 16'd3, 0, 1'b1, 2, 64, 4, 0};
        tbl[4] = '{"two_frames", 16'h8000, 16'd7, 0, 1'b0, 16, 512, 32, 2};
        tbl[5] = '{"gap_ffff_frame", 16'd5, 16'd11, 30, 1'b1, 8, 256, 16, 1};

        rst_n = 1'b0;
        bus.Din_Valid = 1'b0;
        bus.Din = '0;
        fork
            monitor();
        join_none
        #2;
        chk("reset_din_ready", bus.Din_Ready, 1);
        chk("reset_dout_valid", bus.Dout_Valid, 0);
        chk("reset_dout", bus.Dout, 0);
        chk("reset_eol", bus.Dout_Eol, 0);
        chk("reset_done", bus.Frame_Done, 0);

        for (int t = 0; t < 6; t++) begin
            do_reset();
            o0 = out_cnt;
            e0 = eol_cnt;
            d0 = done_cnt;
            for (int r = 0; r < tbl[t].rows; r++)
                send_row(tbl[t].base, tbl[t].step, r * IN_W,
                         tbl[t].gap, tbl[t].ffff, 0);
            bus.Din_Valid = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            chk({tbl[t].name, "_outputs"}, out_cnt - o0, tbl[t].exp_out);
            chk({tbl[t].name, "_eols"}, eol_cnt - e0, tbl[t].exp_eol);
            chk({tbl[t].name, "_dones"}, done_cnt - d0, tbl[t].exp_done);
            chk({tbl[t].name, "_sb_empty"}, sb.size(), 0);
            if (tbl[t].exp_done > 0)
                chk({tbl[t].name, "_done_pos"}, last_done_at - o0,
                    256 * tbl[t].exp_done);
            if (tbl[t].exp_done == 2)
                chk({tbl[t].name, "_done_spacing"}, last_done_at - prev_done_at, 256);
        end

        do_reset();
        for (int r = 0; r < 3; r++) send_row(16'h4000, 16'd1, r * IN_W, 0, 1'b0, 0);
        send_row(16'h4000, 16'd1, 3 * IN_W, 0, 1'b0, 10);
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1;
        o0 = out_cnt;
        for (int r = 0; r < IN_W; r++) send_row(16'h2000, 16'd1, r * IN_W, 0, 1'b0, 0);
        bus.Din_Valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("after_rst_dones", done_cnt - d0, 1);
        chk("after_rst_done_pos", last_done_at - o0, 256);
        chk("after_rst_outputs", out_cnt - o0, 256);
        chk("after_rst_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
